encoder_ham: RTL and testbench

- Hamming(21,16) single-error-correcting encoder. Transmit-side counterpart of the team's Hamming decoder.
- Takes 16-bit data beats over a valid/ready handshake and computes the 5 parity bits. Emits 21-bit codewords whose bit layout matches the decoder exactly.
- Contains a 2-entry skid buffer, so no combinational path exists from rdy_i to rdy_o.
- Optional single-bit error injection and a beat counter support link-level verification.

---
 rtl/encoder_ham.sv | 91 +++++++++
 tb/tb_encoder_ham.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_ham.sv
// Hamming(21,16) SEC encoder with 2-entry skid buffer and optional single-bit
// error injection; codeword layout matches the team's Hamming decoder.
module encoder_ham #(
  parameter bit INJ_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] dat_i,
  input  logic        vld_i,
  output logic        rdy_o,
  input  logic        err_inj_i,
  input  logic [4:0]  err_pos_i,
  output logic [20:0] dat_o,
  output logic        vld_o,
  input  logic        rdy_i,
  output logic [15:0] cnt_o
);

  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] c;
    c        = '0;
    c[2]     = d[0];
    c[6:4]   = d[3:1];
    c[14:8]  = d[10:4];
    c[20:16] = d[15:11];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14] ^ c[16] ^ c[18] ^ c[20];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14] ^ c[17] ^ c[18];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[19] ^ c[20];
    c[7]  = ^c[14:8];
    c[15] = ^c[20:16];
    return c;
  endfunction

  logic [20:0] main_q, skid_q, flip, cw_in;
  logic        main_vld, skid_vld, rdy_q;
  logic [15:0] cnt_q;
  logic        acc, drain;

  // Injection flips one bit after parity, so the decoder sees a true single error.
  always_comb begin
    flip = '0;
    if (INJ_EN && err_inj_i && err_pos_i != 5'd0 && err_pos_i <= 5'd21)
      flip = 21'd1 << (err_pos_i - 5'd1);
    cw_in = encode(dat_i) ^ flip;
  end

  assign acc   = vld_i && rdy_q;
  assign drain = main_vld && rdy_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (drain) cnt_q <= cnt_q + 16'd1;
      if (skid_vld) begin
        // rdy_q is low here, so nothing new can arrive this cycle.
        if (drain) begin
          main_q   <= skid_q;
          skid_vld <= 1'b0;
          rdy_q    <= 1'b1;
        end else begin
          rdy_q    <= 1'b0;
        end
      end else if (acc) begin
        if (!main_vld || drain) begin
          main_q   <= cw_in;
          main_vld <= 1'b1;
          rdy_q    <= 1'b1;
        end else begin
          skid_q   <= cw_in;
          skid_vld <= 1'b1;
          rdy_q    <= 1'b0;
        end
      end else begin
        if (drain) main_vld <= 1'b0;
        rdy_q <= 1'b1;
      end
    end
  end

  assign rdy_o = rdy_q;
  assign dat_o = main_q;
  assign vld_o = main_vld;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_encoder_ham.sv
// Self-checking bench for encoder_ham: vector table, hand sequences for
// backpressure/reset, and a randomized stream against a positional Hamming model.
module tb_encoder_ham;

  logic        clk_i = 1'b0;
  logic        rst_i, vld_i, err_inj_i, rdy_i;
  logic [15:0] dat_i;
  logic [4:0]  err_pos_i;
  logic        rdy_o, vld_o, rdy0, vld0;
  logic [20:0] dat_o, dat0;
  logic [15:0] cnt_o, cnt0;

  int checks = 0;
  int errors = 0;

  encoder_ham #(.INJ_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .err_inj_i(err_inj_i), .err_pos_i(err_pos_i), .dat_o(dat_o), .vld_o(vld_o),
    .rdy_i(rdy_i), .cnt_o(cnt_o));

  encoder_ham #(.INJ_EN(1'b0)) dut_noinj (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .vld_i(vld_i), .rdy_o(rdy0),
    .err_inj_i(err_inj_i), .err_pos_i(err_pos_i), .dat_o(dat0), .vld_o(vld0),
    .rdy_i(rdy_i), .cnt_o(cnt0));

  always #5 clk_i = ~clk_i;

  // Model: data fills the non-power-of-two positions 1..21 in order; parity at
  // position 2^k covers every position whose index has bit k set.
  function automatic logic [20:0] ref_enc(input logic [15:0] d, input logic inj, input int pos);
    logic [20:0] c = '0;
    int j = 0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin c[p-1] = d[j]; j++; end
    for (int k = 0; k < 5; k++) begin
      logic x = 1'b0;
      for (int p = 1; p <= 21; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) x = x ^ c[p-1];
      c[(1 << k) - 1] = x;
    end
    if (inj && pos >= 1 && pos <= 21) c[pos-1] = ~c[pos-1];
    return c;
  endfunction

  function automatic logic [15:0] ref_dec(input logic [20:0] c);
    logic [20:0] x = c;
    logic [15:0] d = '0;
    int syn = 0;
    int j = 0;
    for (int p = 1; p <= 21; p++) if (x[p-1]) syn = syn ^ p;
    if (syn >= 1 && syn <= 21) x[syn-1] = ~x[syn-1];
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin d[j] = x[p-1]; j++; end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [20:0] cw; logic [15:0] d; } beat_t;
  beat_t       sb[$];
  logic [15:0] mcnt = '0;
  logic        stall = 1'b0;
  logic [20:0] stall_dat = '0;

  // Scoreboard: inputs and outputs are sampled mid-cycle, so what is seen here
  // is exactly what transfers at the following rising edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      sb.delete();
      mcnt  = '0;
      stall = 1'b0;
    end else begin
      check("cnt_track", cnt_o, mcnt);
      if (stall) check("hold_stable", {vld_o, dat_o}, {1'b1, stall_dat});
      if (vld_o && rdy_i) begin
        if (sb.size() == 0) begin
          check("spurious_beat", {vld_o, dat_o}, 32'h0);
        end else begin
          check("out_cw", dat_o, sb[0].cw);
          check("out_decode", ref_dec(dat_o), sb[0].d);
          void'(sb.pop_front());
        end
        mcnt = mcnt + 16'd1;
      end
      stall     = vld_o && !rdy_i;
      stall_dat = dat_o;
      if (vld_i && rdy_o)
        sb.push_back('{cw: ref_enc(dat_i, err_inj_i, int'(err_pos_i)), d: dat_i});
    end
  end

  task automatic push_beat(input logic [15:0] d, input logic inj, input logic [4:0] pos);
    int  n = 0;
    logic ok = 1'b0;
    vld_i = 1'b1; dat_i = d; err_inj_i = inj; err_pos_i = pos;
    while (!ok && n < 50) begin
      @(negedge clk_i);
      ok = rdy_o;
      @(posedge clk_i); #1;
      n++;
    end
    vld_i = 1'b0; err_inj_i = 1'b0; err_pos_i = '0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] d; logic inj; logic [4:0] pos; logic [20:0] exp; logic [20:0] exp0;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [15:0] a, b, c;
    tbl[0] = '{16'h0000, 1'b0, 5'd0,  21'h000000, 21'h000000};
    tbl[1] = '{16'hFFFF, 1'b0, 5'd0,  21'h1FFFFE, 21'h1FFFFE};
    tbl[2] = '{16'h0001, 1'b0, 5'd0,  21'h000007, 21'h000007};
    tbl[3] = '{16'h0000, 1'b1, 5'd5,  21'h000010, 21'h000000};
    tbl[4] = '{16'h0000, 1'b1, 5'd0,  21'h000000, 21'h000000};
    tbl[5] = '{16'h0000, 1'b1, 5'd22, 21'h000000, 21'h000000};
    tbl[6] = '{16'h0000, 1'b1, 5'd21, 21'h100000, 21'h000000};
    tbl[7] = '{16'h0001, 1'b1, 5'd1,  21'h000006, 21'h000007};

    rst_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b1; dat_i = '0; err_inj_i = 1'b0; err_pos_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_vld", vld_o, 1'b0);
    check("rst_dat", dat_o, 21'h0);
    check("rst_rdy", rdy_o, 1'b0);
    check("rst_cnt", cnt_o, 16'h0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("rel_rdy_low", rdy_o, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rel_rdy_high", rdy_o, 1'b1);
    @(posedge clk_i); #1;

    // Vector table: one beat at a time, output checked one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      push_beat(tbl[i].d, tbl[i].inj, tbl[i].pos);
      @(negedge clk_i);
      check("tbl_vld", vld_o, 1'b1);
      check("tbl_dat", dat_o, tbl[i].exp);
      check("tbl_noinj_dat", {vld0, dat0}, {1'b1, tbl[i].exp0});
      check("tbl_dec", ref_dec(dat_o), tbl[i].d);
      check("tbl_cnt", cnt_o, 16'(i));
      check("tbl_noinj_cnt", {rdy0, cnt0}, {1'b1, 16'(i)});
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("tbl_cnt_final", cnt_o, 16'd8);
    @(posedge clk_i); #1;

    // Backpressure: third beat must be refused while stalled.
    a = 16'h1234; b = 16'hBEEF; c = 16'h5A5A;
    rdy_i = 1'b0; vld_i = 1'b1; dat_i = a;
    @(negedge clk_i); check("bp_rdy_a", rdy_o, 1'b1);
    @(posedge clk_i); #1 dat_i = b;
    @(negedge clk_i); check("bp_rdy_b", rdy_o, 1'b1);
    check("bp_main_a", {vld_o, dat_o}, {1'b1, ref_enc(a, 1'b0, 0)});
    @(posedge clk_i); #1 dat_i = c;
    @(negedge clk_i); check("bp_rdy_c", rdy_o, 1'b0);
    repeat (3) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("bp_stall_dat", {vld_o, dat_o}, {1'b1, ref_enc(a, 1'b0, 0)});
      check("bp_stall_rdy", rdy_o, 1'b0);
    end
    @(posedge clk_i); #1 rdy_i = 1'b1;
    @(negedge clk_i); check("bp_drain_a", dat_o, ref_enc(a, 1'b0, 0));
    @(posedge clk_i); #1;
    @(negedge clk_i); check("bp_rdy_rise", rdy_o, 1'b1);
    check("bp_out_b", dat_o, ref_enc(b, 1'b0, 0));
    @(posedge clk_i); #1 vld_i = 1'b0;
    @(negedge clk_i); check("bp_out_c", {vld_o, dat_o}, {1'b1, ref_enc(c, 1'b0, 0)});
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("bp_empty", vld_o, 1'b0);
    check("bp_sb_empty", sb.size(), 0);

    // Throughput: fresh counter, 100 back-to-back random beats, most with an error.
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 100; i++) begin
      vld_i = 1'b1; dat_i = 16'($urandom);
      err_inj_i = (i % 4) != 0;
      err_pos_i = 5'($urandom_range(1, 21));
      @(negedge clk_i);
      check("tp_rdy", rdy_o, 1'b1);
      @(posedge clk_i); #1;
    end
    vld_i = 1'b0; err_inj_i = 1'b0;
    @(negedge clk_i); check("tp_last_vld", vld_o, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("tp_cnt", cnt_o, 16'd100);
    check("tp_idle", vld_o, 1'b0);

    // Mid-stream reset with both entries occupied.
    @(posedge clk_i); #1 rdy_i = 1'b0; vld_i = 1'b1; dat_i = 16'hA5A5;
    @(posedge clk_i); #1 dat_i = 16'h3C3C;
    @(posedge clk_i); #1 vld_i = 1'b0;
    @(negedge clk_i);
    check("mr_full", {rdy_o, vld_o}, {1'b0, 1'b1});
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1; rdy_i = 1'b1;
    @(negedge clk_i);
    check("mr_vld", vld_o, 1'b0);
    check("mr_cnt", cnt_o, 16'd0);
    check("mr_rdy_low", rdy_o, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("mr_rdy_high", rdy_o, 1'b1);
    repeat (3) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("mr_no_stale", vld_o, 1'b0);
    end
    check("mr_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
